// File: rtl/uart_tx_arbiter_if.sv
// Producer/UART-side signal bundle for uart_tx_arbiter.
// slave: the arbiter itself; master: the producers plus the UART TX side.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) ();
    logic [NUM_REQ-1:0]   ReqValid;
    logic [NUM_REQ*8-1:0] ReqData;
    logic [NUM_REQ-1:0]   ReqLock;
    logic [NUM_REQ-1:0]   ReqReady;
    logic [7:0]           PalDataIn;
    logic                 PalDataInEn;
    logic                 PalDataInPermit;
    logic [ID_W-1:0]      GrantId;
    logic                 Busy;
    logic [CNT_W-1:0]     TxByteCnt;

    modport master (
        output ReqValid, ReqData, ReqLock, PalDataInPermit,
        input  ReqReady, PalDataIn, PalDataInEn, GrantId, Busy, TxByteCnt
    );

    modport slave (
        input  ReqValid, ReqData, ReqLock, PalDataInPermit,
        output ReqReady, PalDataIn, PalDataInEn, GrantId, Busy, TxByteCnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Optional packet lock is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Rstn,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = ID_W + 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [DATA_W-1:0]   req_byte_c [NUM_REQ];
    logic [NUM_REQ-1:0]  eligible_c;
    logic [NUM_REQ-1:0]  ready_c;
    logic                found_c;
    logic [ID_W-1:0]     sel_c;
    logic                accept_c;
    logic                lock_active_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_byte_c[g] = bus.ReqData[DATA_W*g +: DATA_W];
    end

`ifdef UART_ARB_LOCK_EN
    logic            lock_active_d;
    logic [ID_W-1:0] lock_owner_q, lock_owner_d;

    // While a packet is open only its owner may win, even if it is momentarily idle.
    always_comb begin
        eligible_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible_c[i] = bus.ReqValid[i] & (~lock_active_q | (lock_owner_q == ID_W'(i)));
        end
    end

    always_comb begin
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        if (accept_c) begin
            lock_active_d = bus.ReqLock[sel_c];
            lock_owner_d  = sel_c;
        end
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
        end
    end
`else
    logic unused_lock;

    assign eligible_c    = bus.ReqValid;
    assign lock_active_q = 1'b0;
    assign unused_lock   = ^bus.ReqLock;
`endif

    // Search starts one past the last winner and wraps at NUM_REQ-1.
    always_comb begin
        logic [IDX_W-1:0] idx;
        found_c = 1'b0;
        sel_c   = '0;
        idx     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_REQ)) begin
                idx = idx - IDX_W'(NUM_REQ);
            end
            if (!found_c && eligible_c[idx[ID_W-1:0]]) begin
                found_c = 1'b1;
                sel_c   = idx[ID_W-1:0];
            end
        end
    end

    assign accept_c = Rstn & found_c & (state_q == ST_EMPTY);

    // Next state: load in EMPTY, hand over on Permit in HOLD; no reload in the handover cycle.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        ready_c     = '0;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    ready_c[sel_c] = 1'b1;
                    hold_data_d    = req_byte_c[sel_c];
                    grant_d        = sel_c;
                    ptr_d          = sel_c;
                    state_d        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.PalDataInPermit) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state_q     <= ST_EMPTY;
            hold_data_q <= '0;
            grant_q     <= '0;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.ReqReady    = ready_c;
    assign bus.PalDataIn   = hold_data_q;
    assign bus.PalDataInEn = (state_q == ST_HOLD);
    assign bus.GrantId     = grant_q;
    assign bus.Busy        = (state_q == ST_HOLD) | lock_active_q;
    assign bus.TxByteCnt   = cnt_q;

`ifndef SYNTHESIS
    // Structural invariants of the handshake.
    a_ready_onehot: assert property (@(posedge Clk) disable iff (!Rstn)
        $onehot0(bus.ReqReady));
    a_ready_needs_valid: assert property (@(posedge Clk) disable iff (!Rstn)
        (bus.ReqReady & ~bus.ReqValid) == '0);
    a_hold_stable: assert property (@(posedge Clk) disable iff (!Rstn)
        (bus.PalDataInEn && !bus.PalDataInPermit) |=> (bus.PalDataInEn && $stable(bus.PalDataIn)));
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed producer queues, monitor checks every UART handover.
module tb_uart_tx_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic [7:0]      data;
        logic [ID_W-1:0] id;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .Clk  (clk),
        .Rstn (rst_n),
        .bus  (bus)
    );

    exp_t       exp_q [$];
    logic [8:0] rq [NUM_REQ][$];
    int         checks = 0;
    int         errors = 0;
    int         period = 0;
    int         pcnt   = 0;
    bit         one_shot = 1'b0;
    int         ready_pulses [NUM_REQ];
    int         bad_ready = 0;
    bit         stab_armed = 1'b0;
    logic [7:0] stab_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d, input int id);
        exp_q.push_back(exp_t'{data: d, id: ID_W'(id)});
    endtask

    task automatic push_req(input int i, input logic lock, input logic [7:0] d);
        rq[i].push_back({lock, d});
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            rq[i].delete();
            ready_pulses[i] = 0;
        end
    endtask

    task automatic drive_inputs();
        logic [NUM_REQ-1:0]   v;
        logic [NUM_REQ-1:0]   l;
        logic [NUM_REQ*8-1:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rq[i].size() != 0) begin
                v[i]         = 1'b1;
                l[i]         = rq[i][0][8];
                d[8*i +: 8]  = rq[i][0][7:0];
            end
        end
        bus.ReqValid        = v;
        bus.ReqLock         = l;
        bus.ReqData         = d;
        bus.PalDataInPermit = one_shot || (period != 0 && (pcnt % period) == period - 1);
        one_shot = 1'b0;
        pcnt++;
    endtask

    // One clock: drive at the falling edge, note accepts once ReqReady settles, end at the next falling edge.
    task automatic run_cycles(input int n);
        repeat (n) begin
            drive_inputs();
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.ReqValid[i] && bus.ReqReady[i]) begin
                    ready_pulses[i]++;
                    void'(rq[i].pop_front());
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        clear_reqs();
        exp_q.delete();
        period = 0;
        rst_n  = 1'b0;
        run_cycles(2);
        rst_n  = 1'b1;
    endtask

    // Monitor: every handover must match the scoreboard head; a held byte must not move.
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (stab_armed) begin
                check("hold_en_stable", 32'(bus.PalDataInEn), 32'd1);
                check("hold_data_stable", 32'(bus.PalDataIn), 32'(stab_data));
            end
            if (bus.PalDataInEn && bus.PalDataInPermit) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got byte 0x%0h id %0d expected none",
                             bus.PalDataIn, bus.GrantId);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_byte", 32'(bus.PalDataIn), 32'(e.data));
                    check("xfer_id", 32'(bus.GrantId), 32'(e.id));
                end
            end
            stab_armed = bus.PalDataInEn && !bus.PalDataInPermit;
            stab_data  = bus.PalDataIn;
        end else begin
            stab_armed = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ReqValid        = '0;
        bus.ReqLock         = '0;
        bus.ReqData         = '0;
        bus.PalDataInPermit = 1'b0;
        clear_reqs();

        // 1: reset state, then idle
        #1;
        check("rst_en", 32'(bus.PalDataInEn), 32'd0);
        check("rst_data", 32'(bus.PalDataIn), 32'd0);
        check("rst_gid", 32'(bus.GrantId), 32'd0);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        check("rst_cnt", 32'(bus.TxByteCnt), 32'd0);
        check("rst_ready", 32'(bus.ReqReady), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cycles(10);
        check("idle_ready", 32'(bus.ReqReady), 32'd0);
        check("idle_en", 32'(bus.PalDataInEn), 32'd0);

        // 2: single byte from req1
        push_req(1, 1'b0, 8'hA5);
        expect_byte(8'hA5, 1);
        period = 6;
        pcnt   = 0;
        run_cycles(1);
        check("t2_en_next", 32'(bus.PalDataInEn), 32'd1);
        check("t2_data_next", 32'(bus.PalDataIn), 32'hA5);
        run_cycles(19);
        check("t2_ready_pulses", 32'(ready_pulses[1]), 32'd1);
        check("t2_cnt", 32'(bus.TxByteCnt), 32'd1);
        check("t2_gid", 32'(bus.GrantId), 32'd1);
        check("t2_busy", 32'(bus.Busy), 32'd0);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // 5: packet lock (last winner is req1, so req2 is searched before req0)
        clear_reqs();
        push_req(2, 1'b1, 8'h01);
        push_req(2, 1'b1, 8'h02);
        push_req(2, 1'b0, 8'h03);
        push_req(0, 1'b0, 8'h80);
        push_req(0, 1'b0, 8'h81);
`ifdef UART_ARB_LOCK_EN
        expect_byte(8'h01, 2);
        expect_byte(8'h02, 2);
        expect_byte(8'h03, 2);
        expect_byte(8'h80, 0);
        expect_byte(8'h81, 0);
`else
        expect_byte(8'h01, 2);
        expect_byte(8'h80, 0);
        expect_byte(8'h02, 2);
        expect_byte(8'h81, 0);
        expect_byte(8'h03, 2);
`endif
        period = 6;
        pcnt   = 0;
        run_cycles(45);
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check("t5_cnt", 32'(bus.TxByteCnt), 32'd6);
        check("t5_busy", 32'(bus.Busy), 32'd0);

        // 3: all four requesters continuously valid
        apply_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                push_req(i, 1'b0, 8'(8'h10 + i));
                expect_byte(8'(8'h10 + i), i);
            end
        end
        period = 12;
        pcnt   = 0;
        run_cycles(110);
        check("t3_drained", 32'(exp_q.size()), 32'd0);
        check("t3_cnt", 32'(bus.TxByteCnt), 32'd8);

        // 4: long stall without Permit
        apply_reset();
        push_req(3, 1'b0, 8'h3C);
        expect_byte(8'h3C, 3);
        expect_byte(8'h44, 0);
        run_cycles(1);
        check("t4_gid", 32'(bus.GrantId), 32'd3);
        push_req(0, 1'b0, 8'h44);
        bad_ready = 0;
        repeat (200) begin
            run_cycles(1);
            if (bus.ReqReady !== '0) bad_ready++;
        end
        check("t4_no_ready_in_hold", 32'(bad_ready), 32'd0);
        check("t4_en_held", 32'(bus.PalDataInEn), 32'd1);
        check("t4_data_held", 32'(bus.PalDataIn), 32'h3C);
        check("t4_busy_held", 32'(bus.Busy), 32'd1);
        one_shot = 1'b1;
        run_cycles(1);
        check("t4_busy_after", 32'(bus.Busy), 32'd0);
        check("t4_cnt_after", 32'(bus.TxByteCnt), 32'd1);
        period = 6;
        pcnt   = 0;
        run_cycles(15);
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        check("t4_cnt", 32'(bus.TxByteCnt), 32'd2);

        // 6: reset while holding 0x77
        apply_reset();
        push_req(2, 1'b0, 8'h77);
        run_cycles(3);
        check("t6_en_before", 32'(bus.PalDataInEn), 32'd1);
        check("t6_data_before", 32'(bus.PalDataIn), 32'h77);
        clear_reqs();
        rst_n = 1'b0;
        #1;
        check("t6_en_async", 32'(bus.PalDataInEn), 32'd0);
        check("t6_busy_async", 32'(bus.Busy), 32'd0);
        period = 3;
        pcnt   = 0;
        run_cycles(4);
        period = 0;
        rst_n  = 1'b1;
        push_req(0, 1'b0, 8'hA0);
        push_req(1, 1'b0, 8'hA1);
        expect_byte(8'hA0, 0);
        expect_byte(8'hA1, 1);
        period = 6;
        pcnt   = 0;
        run_cycles(1);
        check("t6_first_gid", 32'(bus.GrantId), 32'd0);
        check("t6_first_data", 32'(bus.PalDataIn), 32'hA0);
        run_cycles(25);
        check("t6_drained", 32'(exp_q.size()), 32'd0);
        check("t6_cnt", 32'(bus.TxByteCnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
